// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - two-requester round-robin ALU issue scheduler with in-order tag pipeline
// Optional build macro ALU_SCHED_OPISO_EN: hold ALU operands between issues instead of zeroing them.
module alu_op_scheduler #(
    parameter int LATENCY = 2,
    parameter int NREQ    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sched_en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][15:0] req_a,
    input  logic [NREQ-1:0][15:0] req_b,
    input  logic [NREQ-1:0][3:0]  req_sel,
    input  logic [NREQ-1:0][3:0]  req_shamt,
    input  logic [NREQ-1:0]       req_cin,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [3:0]            alu_sel,
    output logic [3:0]            alu_shamt,
    output logic                  alu_cin,
    output logic                  alu_issue,
    input  logic [31:0]           alu_result,
    input  logic [15:0]           alu_rem,
    input  logic                  alu_carry,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [31:0]           rsp_result,
    output logic [15:0]           rsp_rem,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic                  idle
);

    logic             prio_q, prio_d;
    logic             gnt_id;
    logic             accept;
    logic [15:0]      a_q, a_d, b_q, b_d;
    logic [3:0]       sel_q, sel_d, shamt_q, shamt_d;
    logic             cin_q, cin_d;
    logic [LATENCY:0] tv_q, tv_d, tid_q, tid_d, terr_q, terr_d;

    always_comb begin
        req_ready = '0;
        gnt_id    = 1'b0;
        if (rst_n && sched_en) begin
            if (req_valid[0] && req_valid[1]) begin
                gnt_id = prio_q;
            end else begin
                gnt_id = req_valid[1];
            end
            if (|req_valid) begin
                req_ready[gnt_id] = 1'b1;
            end
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
`ifdef ALU_SCHED_OPISO_EN
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        shamt_d = shamt_q;
        cin_d   = cin_q;
`else
        a_d     = '0;
        b_d     = '0;
        sel_d   = '0;
        shamt_d = '0;
        cin_d   = 1'b0;
`endif
        prio_d  = prio_q;
        if (accept) begin
            a_d     = req_a[gnt_id];
            b_d     = req_b[gnt_id];
            sel_d   = req_sel[gnt_id];
            shamt_d = req_shamt[gnt_id];
            cin_d   = req_cin[gnt_id];
            prio_d  = ~gnt_id;
        end
    end

    // Stage 0 of the tag pipe is the issue cycle; the last stage lines up with the ALU result.
    always_comb begin
        tv_d   = {tv_q[LATENCY-1:0], accept};
        tid_d  = {tid_q[LATENCY-1:0], gnt_id};
        terr_d = {terr_q[LATENCY-1:0], (req_sel[gnt_id] >= 4'd10)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            shamt_q <= '0;
            cin_q   <= 1'b0;
            tv_q    <= '0;
            tid_q   <= '0;
            terr_q  <= '0;
        end else begin
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            shamt_q <= shamt_d;
            cin_q   <= cin_d;
            tv_q    <= tv_d;
            tid_q   <= tid_d;
            terr_q  <= terr_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign alu_shamt  = shamt_q;
    assign alu_cin    = cin_q;
    assign alu_issue  = tv_q[0];

    assign rsp_valid  = tv_q[LATENCY];
    assign rsp_id     = tid_q[LATENCY] & rsp_valid;
    assign rsp_err    = terr_q[LATENCY] & rsp_valid;
    assign rsp_result = rsp_valid ? alu_result : 32'd0;
    assign rsp_rem    = rsp_valid ? alu_rem : 16'd0;
    assign rsp_carry  = rsp_valid & alu_carry;

    assign idle = ~(|tv_q | |req_valid);

endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving the ALU result latency in cycles from operand sampling.
REQ-002 The block SHALL have parameter NREQ, fixed at 2, giving the number of requester ports (0 and 1).
REQ-003 clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 sched_en  input  1  when low, no new grants are issued and in-flight operations drain normally.
REQ-006 req_valid  input  2  request valid, one bit per requester.
REQ-007 req_ready  output  2  grant/accept, one bit per requester; at most one bit is high at a time.
REQ-008 req_a, req_b  input  2x16  operands per requester.
REQ-009 req_sel  input  2x4  opcode per requester: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4-7 shifts, 8 INC, 9 DEC.
REQ-010 req_shamt  input  2x4  shift amount; req_cin  input  2x1  carry-in.
REQ-011 alu_a, alu_b  output  16  registered operands to the ALU.
REQ-012 alu_sel, alu_shamt  output  4  registered opcode and shift amount; alu_cin  output  1  registered carry-in.
REQ-013 alu_issue  output  1  high in the cycle a valid operation is presented to the ALU.
REQ-014 alu_result  input  32; alu_rem  input  16; alu_carry  input  1  ALU outputs.
REQ-015 rsp_valid  output  1  one-cycle response strobe; rsp_id  output  1  originating requester.
REQ-016 rsp_result  output  32, rsp_rem  output  16, rsp_carry  output  1  ALU outputs passed through while rsp_valid is high, and zero otherwise.
REQ-017 rsp_err  output  1  high with rsp_valid when the issued opcode was 10-15.
REQ-018 idle  output  1  high when nothing is in flight and no req_valid bit is high.

Function
REQ-019 A request SHALL be accepted on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-020 req_ready SHALL be combinational: it is low for both ports when sched_en is low or rst_n is low; otherwise it goes to the single valid requester, or to the round-robin winner when both are valid.
REQ-021 Round-robin: a priority pointer SHALL reset to requester 0 and, after each acceptance, point to the requester that was not granted; this bounds starvation to one grant.
REQ-022 At most one operation SHALL be accepted per cycle, with throughput of one operation per cycle and no bubbles under back-to-back requests.
REQ-023 Accepted fields SHALL be registered onto the alu_* outputs at the accepting edge, and alu_issue SHALL be high during the following cycle.
REQ-024 A tag pipeline of depth LATENCY+1 SHALL carry {valid, id, err}; rsp_valid SHALL assert exactly LATENCY+1 cycles after the accepting edge, i.e. 3 cycles at default.
REQ-025 Opcodes 10-15 SHALL still be accepted and issued, and their response SHALL carry rsp_err=1.
REQ-026 Responses SHALL have no backpressure and SHALL return in issue order.
REQ-027 When sched_en is deasserted mid-stream, already-accepted operations SHALL still respond.
REQ-028 idle SHALL be registered-free logic: the NOR of all tag-pipe valid bits, alu_issue and req_valid.

Reset
REQ-029 When rst_n is low at a rising edge, all alu_* outputs, alu_issue, the tag pipeline, rsp_* outputs and the round-robin pointer SHALL clear to 0, and idle SHALL read 1.
REQ-030 Reset asserted with operations in flight SHALL drop them, and no rsp_valid SHALL appear for those operations after reset is released.
REQ-031 The first grant after reset release SHALL go to requester 0 if both requesters are valid.

Configuration
REQ-032 The block SHALL support macro ALU_SCHED_OPISO_EN (operand isolation for power).
REQ-033 With ALU_SCHED_OPISO_EN defined, alu_a, alu_b, alu_sel, alu_shamt and alu_cin SHALL hold their last issued values in cycles with no acceptance, so the ALU inputs do not toggle.
REQ-034 Without ALU_SCHED_OPISO_EN, those outputs SHALL load 0 in cycles with no acceptance.
REQ-035 alu_issue and response timing SHALL be identical in both builds.

Verification
REQ-036 Requester 0 sends ADD 555+4350 with cin=0 -> rsp_valid 3 cycles later with rsp_id=0, rsp_result=4905, rsp_err=0.
REQ-037 Both requesters are valid with continuous requests (req0 MUL 255x255, req1 SUB 5000-1234) -> grants alternate 0,1,0,1 and responses carry 65025 and 3766 with matching ids, one per cycle.
REQ-038 Requester 1 sends sel=12 -> the request is accepted and rsp_err=1 with rsp_id=1 after 3 cycles.
REQ-039 Three back-to-back operations are accepted, then rst_n is pulled low for 1 cycle -> no rsp_valid appears afterward, all outputs are 0, and idle=1.
REQ-040 sched_en is driven low while req_valid=2'b11 -> req_ready=0, in-flight operations still respond, and idle rises once drained and the requesters drop.
REQ-041 Idle cycles between operations -> with ALU_SCHED_OPISO_EN alu_a holds its last value; without it alu_a=0.
